// File: rtl/fx_issue_scheduler_if.sv
// fx_issue_scheduler_if: dispatch, hold/flush, writeback and issue signals of the FX issue scheduler.
//   master: dispatch/FX side. Drives flush, dispatch payload, hold and writeback. Receives ready, issue payload and pendingCount.
//   slave : the scheduler, with the opposite directions.
interface fx_issue_scheduler_if #(
  parameter int regWidth = 5,
  parameter int opcodeWidth = 6,
  parameter int xOpCodeWidth = 10,
  parameter int immWith = 24,
  parameter int formatIndexRange = 5
);
  logic flush_i, dispValid_i, dispReady_o, hold_i, wbEnable_i, issueEnable_o;
  logic dispBit1_i, dispBit2_i, dispDestV_i, dispSrcAV_i, dispSrcBV_i, issueBit1_o, issueBit2_o;
  logic [opcodeWidth-1:0] dispOpCode_i, issueOpCode_o;
  logic [xOpCodeWidth-1:0] dispXOpCode_i, issueXOpCode_o;
  logic [formatIndexRange-1:0] dispFormat_i, issueFormat_o;
  logic [immWith-1:0] dispImm_i, issueImm_o;
  logic [63:0] dispAddr_i, issueAddr_o;
  logic [regWidth-1:0] dispDest_i, dispSrcA_i, dispSrcB_i, wbAddress_i;
  logic [regWidth-1:0] issueDest_o, issueSrcA_o, issueSrcB_o;
  logic [2:0] issueUnitCode_o;
  logic [regWidth:0] pendingCount_o;
  modport master (
    output flush_i, dispValid_i, dispOpCode_i, dispXOpCode_i, dispFormat_i, dispImm_i, dispBit1_i,
           dispBit2_i, dispAddr_i, dispDest_i, dispSrcA_i, dispSrcB_i, dispDestV_i, dispSrcAV_i,
           dispSrcBV_i, hold_i, wbEnable_i, wbAddress_i,
    input  dispReady_o, issueEnable_o, issueUnitCode_o, issueOpCode_o, issueXOpCode_o, issueFormat_o,
           issueImm_o, issueBit1_o, issueBit2_o, issueAddr_o, issueDest_o, issueSrcA_o, issueSrcB_o,
           pendingCount_o
  );
  modport slave (
    input  flush_i, dispValid_i, dispOpCode_i, dispXOpCode_i, dispFormat_i, dispImm_i, dispBit1_i,
           dispBit2_i, dispAddr_i, dispDest_i, dispSrcA_i, dispSrcB_i, dispDestV_i, dispSrcAV_i,
           dispSrcBV_i, hold_i, wbEnable_i, wbAddress_i,
    output dispReady_o, issueEnable_o, issueUnitCode_o, issueOpCode_o, issueXOpCode_o, issueFormat_o,
           issueImm_o, issueBit1_o, issueBit2_o, issueAddr_o, issueDest_o, issueSrcA_o, issueSrcB_o,
           pendingCount_o
  );
endinterface

// File: rtl/fx_issue_scheduler.sv
// fx_issue_scheduler: in-order FX issue queue with a GPR pending-writeback scoreboard.
//   clock_i : rising-edge clock.
//   reset_i : asynchronous active-low reset.
//   bus     : fx_issue_scheduler_if.slave. Carries the dispatch push, hold/flush, FX reg1 writeback, the registered issue payload and pendingCount.
//   Macro FX_SCHED_WB_BYPASS_EN lets a same-cycle writeback satisfy the issue check.
module fx_issue_scheduler #(
  parameter int QUEUE_DEPTH = 4,
  parameter int regWidth = 5,
  parameter int opcodeWidth = 6,
  parameter int xOpCodeWidth = 10,
  parameter int immWith = 24,
  parameter int formatIndexRange = 5,
  parameter int FXUnitCode = 0
) (
  input logic clock_i,
  input logic reset_i,
  fx_issue_scheduler_if.slave bus
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int NR = 2 ** regWidth;
  typedef struct packed {
    logic [opcodeWidth-1:0] op;
    logic [xOpCodeWidth-1:0] xop;
    logic [formatIndexRange-1:0] fmt;
    logic [immWith-1:0] imm;
    logic b1, b2;
    logic [63:0] addr;
    logic [regWidth-1:0] d, a, b;
  } pay_t;
  typedef struct packed {
    pay_t p;
    logic dv, av, bv;
  } entry_t;
  entry_t q [QUEUE_DEPTH];
  entry_t din, hd;
  pay_t out;
  logic [AW-1:0] head, tail;
  logic [AW:0] count, count_next;
  logic [NR-1:0] sb, sb_next, pend, wb_mask;
  logic [regWidth:0] pcnt;
  logic push, issue, hazard, ready;
  assign din = {bus.dispOpCode_i, bus.dispXOpCode_i, bus.dispFormat_i, bus.dispImm_i, bus.dispBit1_i,
                bus.dispBit2_i, bus.dispAddr_i, bus.dispDest_i, bus.dispSrcA_i, bus.dispSrcB_i,
                bus.dispDestV_i, bus.dispSrcAV_i, bus.dispSrcBV_i};
  assign hd = q[head];
  assign wb_mask = {NR{bus.wbEnable_i}} & (NR'(1) << bus.wbAddress_i);
`ifdef FX_SCHED_WB_BYPASS_EN
  assign pend = sb & ~wb_mask;
`else
  assign pend = sb;
`endif
  // Dest is checked as well as sources so a younger write never lands before an older one.
  assign hazard = (hd.av & pend[hd.p.a]) | (hd.bv & pend[hd.p.b]) | (hd.dv & pend[hd.p.d]);
  assign push = bus.dispValid_i & ready & ~bus.flush_i;
  assign issue = (|count) & ~bus.hold_i & ~bus.flush_i & ~hazard;
  assign count_next = bus.flush_i ? '0 : count + (AW+1)'(push) - (AW+1)'(issue);
  // Set is applied after clear so a same-edge issue to the writeback register stays pending.
  assign sb_next = (sb & ~wb_mask) | ({NR{issue & hd.dv}} & (NR'(1) << hd.p.d));
  always_comb begin
    pcnt = '0;
    for (int i = 0; i < NR; i++) pcnt = pcnt + (regWidth+1)'(sb[i]);
  end
  assign bus.pendingCount_o = pcnt;
  assign bus.dispReady_o = ready;
  assign {bus.issueOpCode_o, bus.issueXOpCode_o, bus.issueFormat_o, bus.issueImm_o, bus.issueBit1_o,
          bus.issueBit2_o, bus.issueAddr_o, bus.issueDest_o, bus.issueSrcA_o, bus.issueSrcB_o} = out;
  always_ff @(posedge clock_i)
    if (push) q[tail] <= din;
  always_ff @(posedge clock_i or negedge reset_i)
    if (!reset_i) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      sb <= '0;
      ready <= 1'b1;
      out <= '0;
      bus.issueEnable_o <= 1'b0;
      bus.issueUnitCode_o <= '0;
    end else begin
      head <= bus.flush_i ? tail : head + AW'(issue);
      tail <= tail + AW'(push);
      count <= count_next;
      sb <= sb_next;
      ready <= count_next < (AW+1)'(QUEUE_DEPTH);
      out <= issue ? hd.p : out;
      bus.issueEnable_o <= issue;
      bus.issueUnitCode_o <= issue ? 3'(FXUnitCode) : 3'd0;
    end
endmodule

// File: tb/tb_fx_issue_scheduler.sv
// tb_fx_issue_scheduler: vector table plus payload scoreboard for fx_issue_scheduler.
`define CHK(n, a, r) chk(n, 128'(a), 128'(r))
module tb_fx_issue_scheduler;
  localparam int UC = 5;
`ifdef FX_SCHED_WB_BYPASS_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 3;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fx_issue_scheduler_if bus();
  fx_issue_scheduler #(.FXUnitCode(UC)) dut (.clock_i(clk), .reset_i(rst_n), .bus(bus));
  typedef struct packed {
    logic [5:0] op;
    logic [9:0] xop;
    logic [4:0] fmt;
    logic [23:0] imm;
    logic b1, b2;
    logic [63:0] addr;
    logic [4:0] d, a, b;
  } pay_t;
  typedef struct {
    int dv, d, a, av, hold, flush, wbv, wba, e_iss, e_rdy, e_pend;
  } vec_t;
  vec_t tbl[$];
  pay_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int seq = 0;
  logic fx_on = 1'b0, fx1 = 1'b0, fx2 = 1'b0;
  logic [4:0] fx1a = '0, fx2a = '0;
  task automatic chk(string nm, logic [127:0] act, logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask
  function automatic pay_t mk(int s, int d, int a, int b);
    pay_t p;
    p.op = 6'(s + 1);
    p.xop = 10'(s * 37 + 5);
    p.fmt = 5'(s + 2);
    p.imm = 24'(s * 4369 + 1);
    p.b1 = s[0];
    p.b2 = s[1];
    p.addr = 64'h1000_0000 + 64'(s) * 64'd4;
    p.d = 5'(d);
    p.a = 5'(a);
    p.b = 5'(b);
    return p;
  endfunction
  function automatic pay_t got();
    return {bus.issueOpCode_o, bus.issueXOpCode_o, bus.issueFormat_o, bus.issueImm_o, bus.issueBit1_o,
            bus.issueBit2_o, bus.issueAddr_o, bus.issueDest_o, bus.issueSrcA_o, bus.issueSrcB_o};
  endfunction
  function automatic vec_t row(int dv, int d, int a, int av, int hold, int flush, int wbv, int wba,
                               int e_iss, int e_rdy, int e_pend);
    vec_t v;
    v = '{dv, d, a, av, hold, flush, wbv, wba, e_iss, e_rdy, e_pend};
    return v;
  endfunction
  // Drive one cycle's inputs at a falling edge, then observe at the next falling edge.
  // The FX model writes back the issued dest two cycles after issueEnable_o is seen.
  task automatic tick(int dv, int d, int a, int b, int dvld, int av, int bv, int hold, int flush,
                      int wbv, int wba);
    pay_t p;
    p = mk(seq, d, a, b);
    {bus.dispOpCode_i, bus.dispXOpCode_i, bus.dispFormat_i, bus.dispImm_i, bus.dispBit1_i, bus.dispBit2_i,
     bus.dispAddr_i, bus.dispDest_i, bus.dispSrcA_i, bus.dispSrcB_i} = p;
    bus.dispValid_i = dv[0];
    bus.dispDestV_i = dvld[0];
    bus.dispSrcAV_i = av[0];
    bus.dispSrcBV_i = bv[0];
    bus.hold_i = hold[0];
    bus.flush_i = flush[0];
    bus.wbEnable_i = wbv[0] | (fx_on & fx2);
    bus.wbAddress_i = wbv[0] ? 5'(wba) : fx2a;
    if (flush != 0) exp_q.delete();
    else if (dv != 0 && bus.dispReady_o) begin
      exp_q.push_back(p);
      seq++;
    end
    @(negedge clk);
    fx2 = fx1;
    fx2a = fx1a;
    fx1 = bus.issueEnable_o;
    fx1a = bus.issueDest_o;
    if (bus.issueEnable_o) begin
      `CHK("unit_code", bus.issueUnitCode_o, UC);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_issue: got payload %0h, required no issue", got());
      end else `CHK("payload", got(), exp_q.pop_front());
    end
  endtask
  task automatic idle();
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic chk_reset(string tag);
    `CHK({tag, "_issue"}, bus.issueEnable_o, 0);
    `CHK({tag, "_ready"}, bus.dispReady_o, 1);
    `CHK({tag, "_pending"}, bus.pendingCount_o, 0);
    `CHK({tag, "_unit"}, bus.issueUnitCode_o, 0);
    `CHK({tag, "_payload"}, got(), 0);
  endtask
  task automatic restart();
    rst_n = 1'b0;
    exp_q.delete();
    fx1 = 1'b0;
    fx2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    automatic int t1, t2;
    bus.dispValid_i = 1'b0;
    bus.hold_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.wbEnable_i = 1'b0;
    bus.wbAddress_i = '0;
    // Independent ops r3,r4,r5: issue each one cycle after its push, three pending.
    tbl.push_back(row(1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(row(1, 4, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(row(1, 5, 0, 0, 0, 0, 0, 0, 1, 1, 2));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3));
    // Fill under hold: fifth offer refused, ready back one cycle after the first issue.
    tbl.push_back(row(1, 10, 0, 0, 1, 0, 0, 0, 0, 1, 3));
    tbl.push_back(row(1, 11, 0, 0, 1, 0, 0, 0, 0, 1, 3));
    tbl.push_back(row(1, 12, 0, 0, 1, 0, 0, 0, 0, 1, 3));
    tbl.push_back(row(1, 13, 0, 0, 1, 0, 0, 0, 0, 0, 3));
    tbl.push_back(row(1, 14, 0, 0, 1, 0, 0, 0, 0, 0, 3));
    tbl.push_back(row(1, 14, 0, 0, 0, 0, 0, 0, 1, 1, 4));
    tbl.push_back(row(1, 14, 0, 0, 0, 0, 0, 0, 1, 1, 5));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 8));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8));
    // Three ops blocked behind r3, flushed; later r3 writeback still clears; stray writeback is harmless.
    tbl.push_back(row(1, 20, 3, 1, 0, 0, 0, 0, 0, 1, 8));
    tbl.push_back(row(1, 21, 0, 0, 0, 0, 0, 0, 0, 1, 8));
    tbl.push_back(row(1, 22, 0, 0, 0, 0, 0, 0, 0, 1, 8));
    tbl.push_back(row(1, 23, 0, 0, 0, 1, 0, 0, 0, 1, 8));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 7));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 31, 0, 1, 7));
    // Issue to r7 on the same edge as a writeback to r7: r7 stays pending.
    tbl.push_back(row(1, 7, 0, 0, 0, 0, 0, 0, 0, 1, 7));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 7, 1, 1, 8));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8));
    restart();
    chk_reset("reset");
    foreach (tbl[i]) begin
      tick(tbl[i].dv, tbl[i].d, tbl[i].a, 0, 1, tbl[i].av, 0, tbl[i].hold, tbl[i].flush, tbl[i].wbv, tbl[i].wba);
      `CHK($sformatf("v%0d_issue", i), bus.issueEnable_o, tbl[i].e_iss);
      `CHK($sformatf("v%0d_ready", i), bus.dispReady_o, tbl[i].e_rdy);
      `CHK($sformatf("v%0d_pending", i), bus.pendingCount_o, tbl[i].e_pend);
    end
    // Asynchronous reset with three entries queued, checked before any clock edge.
    for (int i = 0; i < 3; i++) tick(1, 24 + i, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk_reset("async");
    restart();
    idle();
    idle();
    `CHK("post_reset_empty", bus.issueEnable_o, 0);
    // Hazards through the FX model: srcA, srcB, dest, then valid bits off.
    fx_on = 1'b1;
    for (int k = 0; k < 4; k++) begin
      t1 = -1;
      t2 = -1;
      for (int c = 0; c < 10; c++) begin
        if (c == 0) tick(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        else if (c == 1) tick(1, (k == 2) ? 3 : 9, 3, 3, (k == 3) ? 0 : 1, (k == 0) ? 1 : 0, (k == 1) ? 1 : 0, 0, 0, 0, 0);
        else idle();
        if (bus.issueEnable_o) begin
          if (t1 < 0) t1 = c;
          else if (t2 < 0) t2 = c;
        end
      end
      `CHK($sformatf("hazard%0d_gap", k), t2 - t1, (k == 3) ? 1 : GAP);
      `CHK($sformatf("hazard%0d_drained", k), bus.pendingCount_o, 0);
    end
    `CHK("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
